// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares the memory_controller read port between the
// kernel-load (0) and image-fetch (1) paths, round-robin on ties, with watchdog.
module mem_request_arbiter #(
    parameter int ADDR_W  = 48,
    parameter int DATA_W  = 48,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [1:0]        CTRL0,
    input  logic [1:0]        CTRL1,
    input  logic [1:0]        INDEX0,
    input  logic [1:0]        INDEX1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    output logic              DONE0,
    output logic              DONE1,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic              GRANT,
    output logic              BUSY,
    output logic              MC_ENABLE,
    output logic [1:0]        MC_CTRL,
    output logic [1:0]        MC_INDEX,
    output logic [ADDR_W-1:0] MC_ADDRESS,
    input  logic              MC_HANDSHAKE,
    input  logic [DATA_W-1:0] MC_READ
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic          last_grant;
    logic [TW-1:0] timer;

    logic              req_any;
    logic              winner;
    logic              timed_out;
    logic              load;
    logic              capture;
    logic              abort;
    logic              timer_inc;
    logic [1:0]        ctrl_sel;
    logic [1:0]        index_sel;
    logic [ADDR_W-1:0] addr_sel;

    // A tie goes to whichever requester did not win last time.
    always_comb begin
        req_any = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            winner = ~last_grant;
        end else begin
            winner = REQ1;
        end
        if (winner) begin
            ctrl_sel  = CTRL1;
            index_sel = INDEX1;
            addr_sel  = ADDR1;
        end else begin
            ctrl_sel  = CTRL0;
            index_sel = INDEX0;
            addr_sel  = ADDR0;
        end
        timed_out = (timer == TLAST);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (MC_HANDSHAKE || timed_out) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake has priority over the watchdog on the final timer cycle.
    always_comb begin
        load      = (state == IDLE) && req_any;
        capture   = (state == WAIT) && MC_HANDSHAKE;
        abort     = (state == WAIT) && !MC_HANDSHAKE && timed_out;
        timer_inc = (state == WAIT) && !MC_HANDSHAKE && !timed_out;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant <= 1'b1;
            timer      <= '0;
            GRANT      <= 1'b0;
            MC_CTRL    <= '0;
            MC_INDEX   <= '0;
            MC_ADDRESS <= '0;
            RDATA      <= '0;
            ERR        <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            MC_ENABLE  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            MC_ENABLE <= (state_nx == WAIT);
            BUSY      <= (state_nx != IDLE);
            DONE0     <= (state_nx == RELEASE) && !GRANT;
            DONE1     <= (state_nx == RELEASE) && GRANT;
            ERR       <= abort;
            if (load) begin
                GRANT      <= winner;
                last_grant <= winner;
                MC_CTRL    <= ctrl_sel;
                MC_INDEX   <= index_sel;
                MC_ADDRESS <= addr_sel;
                timer      <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (capture) begin
                RDATA <= MC_READ;
            end
        end
    end

    a_one_done : assert property (
        @(posedge CLK) disable iff (!RESET) !(DONE0 && DONE1));
    a_en_busy : assert property (
        @(posedge CLK) disable iff (!RESET) MC_ENABLE |-> BUSY);

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter: random requesters and a stub controller checked
// against a transaction-level model of grants, windows and completions.
module tb_mem_request_arbiter;

    localparam int AW = 48;
    localparam int DW = 48;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req [2];
    logic [1:0]    ctrl [2];
    logic [1:0]    idx [2];
    logic [AW-1:0] addr [2];
    logic          DONE0, DONE1, ERR, GRANT, BUSY, MC_ENABLE;
    logic [DW-1:0] RDATA;
    logic [1:0]    MC_CTRL, MC_INDEX;
    logic [AW-1:0] MC_ADDRESS;
    logic          MC_HANDSHAKE;
    logic [DW-1:0] MC_READ;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_request_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ0        (req[0]),
        .REQ1        (req[1]),
        .CTRL0       (ctrl[0]),
        .CTRL1       (ctrl[1]),
        .INDEX0      (idx[0]),
        .INDEX1      (idx[1]),
        .ADDR0       (addr[0]),
        .ADDR1       (addr[1]),
        .DONE0       (DONE0),
        .DONE1       (DONE1),
        .ERR         (ERR),
        .RDATA       (RDATA),
        .GRANT       (GRANT),
        .BUSY        (BUSY),
        .MC_ENABLE   (MC_ENABLE),
        .MC_CTRL     (MC_CTRL),
        .MC_INDEX    (MC_INDEX),
        .MC_ADDRESS  (MC_ADDRESS),
        .MC_HANDSHAKE(MC_HANDSHAKE),
        .MC_READ     (MC_READ)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model state
    bit            last = 1'b1;
    bit            in_win = 1'b0;
    bit            win_who = 1'b0;
    bit            done_now = 1'b0;
    int            win_len = 0;
    int            lat = 0;
    int            gap = 2;
    logic [AW-1:0] win_addr;
    logic [1:0]    win_ctrl, win_idx;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] hs_data = '0;
    bit            p_req [2];
    logic [AW-1:0] p_addr [2];
    logic [1:0]    p_ctrl [2];
    logic [1:0]    p_idx [2];

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic new_cmd(input int x);
        ctrl[x] = 2'($urandom_range(0, 3));
        idx[x]  = 2'($urandom_range(0, 3));
        addr[x] = AW'(rnd64());
    endtask

    task automatic snap();
        for (int x = 0; x < 2; x++) begin
            p_req[x]  = req[x];
            p_addr[x] = addr[x];
            p_ctrl[x] = ctrl[x];
            p_idx[x]  = idx[x];
        end
    endtask

    task automatic monitor();
        bit w;
        int exp_len;
        bit exp_err;
        if (MC_ENABLE) begin
            if (!in_win) begin
                chk("req_before_grant", 64'(p_req[0] | p_req[1]), 64'd1);
                chk("enable_gap", 64'(gap >= 2), 64'd1);
                w = (p_req[0] && p_req[1]) ? ~last : p_req[1];
                last     = w;
                win_who  = w;
                win_addr = p_addr[w];
                win_ctrl = p_ctrl[w];
                win_idx  = p_idx[w];
                chk("grant", 64'(GRANT), 64'(w));
                in_win  = 1'b1;
                win_len = 0;
                lat     = $urandom_range(1, TO + 3);
            end
            win_len++;
            chk("mc_address", 64'(MC_ADDRESS), 64'(win_addr));
            chk("mc_ctrl", 64'(MC_CTRL), 64'(win_ctrl));
            chk("mc_index", 64'(MC_INDEX), 64'(win_idx));
            chk("busy_wait", 64'(BUSY), 64'd1);
            chk("done_in_wait", 64'({DONE1, DONE0}), 64'd0);
        end else if (in_win) begin
            in_win  = 1'b0;
            exp_err = (lat > TO);
            exp_len = exp_err ? TO : lat;
            if (!exp_err) exp_rdata = hs_data;
            chk("enable_len", 64'(win_len), 64'(exp_len));
            chk("done0", 64'(DONE0), 64'(win_who == 1'b0));
            chk("done1", 64'(DONE1), 64'(win_who == 1'b1));
            chk("err", 64'(ERR), 64'(exp_err));
            chk("rdata", 64'(RDATA), 64'(exp_rdata));
            chk("busy_release", 64'(BUSY), 64'd1);
            chk("grant_release", 64'(GRANT), 64'(win_who));
            done_now = 1'b1;
            gap      = 1;
        end else begin
            gap++;
            chk("done_idle", 64'({DONE1, DONE0}), 64'd0);
            chk("err_idle", 64'(ERR), 64'd0);
            chk("busy_idle", 64'(BUSY), 64'd0);
            chk("rdata_hold", 64'(RDATA), 64'(exp_rdata));
        end
    endtask

    task automatic drive();
        for (int x = 0; x < 2; x++) begin
            if (done_now && win_who == 1'(x)) begin
                if ($urandom_range(0, 1) == 0) req[x] = 1'b0;
                else new_cmd(x);
            end else if (!req[x]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[x] = 1'b1;
                    new_cmd(x);
                end
            end else if (in_win && win_who == 1'(x) && $urandom_range(0, 9) == 0) begin
                req[x] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                addr[x] = AW'(rnd64());
                ctrl[x] = 2'($urandom_range(0, 3));
            end
        end
        done_now = 1'b0;
        MC_READ  = DW'(rnd64());
        if (in_win) begin
            MC_HANDSHAKE = (win_len == lat);
            if (win_len == lat) hs_data = MC_READ;
        end else begin
            MC_HANDSHAKE = 1'($urandom_range(0, 1));
        end
        snap();
    endtask

    task automatic cycle();
        @(negedge CLK);
        monitor();
        drive();
    endtask

    initial begin
        int n;
        RESET        = 1'b0;
        MC_HANDSHAKE = 1'b0;
        MC_READ      = '0;
        for (int x = 0; x < 2; x++) begin
            req[x] = 1'b0;
            new_cmd(x);
        end
        repeat (3) @(negedge CLK);
        chk("rst_enable", 64'(MC_ENABLE), 64'd0);
        chk("rst_done", 64'({DONE1, DONE0}), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_grant", 64'(GRANT), 64'd0);
        chk("rst_cmd", 64'({MC_CTRL, MC_INDEX}), 64'd0);
        chk("rst_address", 64'(MC_ADDRESS), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);

        // tie straight out of reset: requester 0 must win first
        req[0] = 1'b1;
        req[1] = 1'b1;
        snap();
        RESET = 1'b1;
        repeat (3000) cycle();

        n = 0;
        while (!(in_win && win_len == 2) && n < 500) begin
            cycle();
            n++;
        end
        chk("reach_wait2", 64'(in_win && win_len == 2), 64'd1);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_enable", 64'(MC_ENABLE), 64'd0);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_grant", 64'(GRANT), 64'd0);
        chk("midrst_done", 64'({DONE1, DONE0}), 64'd0);
        repeat (2) begin
            @(negedge CLK);
            chk("rst_hold_done", 64'({DONE1, DONE0}), 64'd0);
            chk("rst_hold_enable", 64'(MC_ENABLE), 64'd0);
        end
        last      = 1'b1;
        in_win    = 1'b0;
        done_now  = 1'b0;
        gap       = 2;
        exp_rdata = '0;
        req[0] = 1'b1;
        req[1] = 1'b1;
        new_cmd(0);
        new_cmd(1);
        MC_HANDSHAKE = 1'b0;
        snap();
        RESET = 1'b1;
        repeat (60) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
